// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch/data requester ports and memory-side bus for mem_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_fn3;
    logic        d_valid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_fn3;
    logic [31:0] mem_rdata;

    logic        busy;

    // Environment view: requesters plus memory
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_fn3, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_fn3, busy
    );

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_fn3, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_fn3, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch/data) single-outstanding memory arbiter with
//               data priority and fetch starvation protection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0] c_FN3_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_owner;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [2:0]         r_mem_fn3;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;

    logic w_arb;
    logic w_starved;
    logic w_if_win;
    logic w_d_win;
    logic w_mem_en;
    logic w_if_valid;
    logic w_d_valid;
    logic w_busy;

    assign w_arb     = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_starved = (r_starve_cnt == c_CNT_W'(STARVE_LIMIT));
    assign w_if_win  = w_arb && bus.if_req && (!bus.d_req || w_starved);
    assign w_d_win   = w_arb && bus.d_req && !w_if_win;

    always_comb begin
        w_next_state = r_state;
        w_mem_en     = 1'b0;
        w_if_valid   = 1'b0;
        w_d_valid    = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = (w_if_win || w_d_win) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                w_mem_en     = 1'b1;
                w_busy       = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_busy       = 1'b1;
                w_if_valid   = !r_owner;
                w_d_valid    = r_owner;
                w_next_state = (w_if_win || w_d_win) ? S_ISSUE : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_owner      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_fn3    <= 3'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            r_state <= w_next_state;

            if (w_if_win) begin
                r_owner     <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= 32'd0;
                r_mem_fn3   <= c_FN3_WORD;
            end else if (w_d_win) begin
                r_owner     <= 1'b1;
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                r_mem_fn3   <= bus.d_fn3;
            end

            // Counts only losses the fetch port actually suffered while waiting
            if (!bus.if_req || w_if_win) begin
                r_starve_cnt <= '0;
            end else if (w_d_win && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (w_if_valid) begin
                r_if_rdata <= bus.mem_rdata;
            end
            if (w_d_valid && !r_mem_we) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    // Read data is forwarded in the response cycle, then held
    assign bus.if_rdata  = w_if_valid ? bus.mem_rdata : r_if_rdata;
    assign bus.d_rdata   = (w_d_valid && !r_mem_we) ? bus.mem_rdata : r_d_rdata;
    assign bus.if_valid  = w_if_valid;
    assign bus.d_valid   = w_d_valid;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_fn3   = r_mem_fn3;
    assign bus.busy      = w_busy;

endmodule

`default_nettype wire
